// File: rtl/cam_pwr_pkg.sv
// -----------------------------------------------------------------------------
// cam_pwr_pkg
// Shared definitions for the camera power controller:
//   - state_t        : 4-bit FSM state encoding
//   - FC_*           : 3-bit fault codes reported on fault_code_o
//   - DEF_*          : default delay parameters (in ctrl_clk_i cycles)
//   - EN_*           : bit positions inside the controller's enable vector
//   - is_busy()      : true for every power-up / power-down step
// Optional build macro used by the controller: CAM_PWR_PGOOD_CHECK_EN
// -----------------------------------------------------------------------------
package cam_pwr_pkg;

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_UP_1V2  = 4'd1,
        ST_UP_1V8  = 4'd2,
        ST_UP_3V3  = 4'd3,
        ST_UP_XCLR = 4'd4,
        ST_UP_INCK = 4'd5,
        ST_READY   = 4'd6,
        ST_DN_INCK = 4'd7,
        ST_DN_XCLR = 4'd8,
        ST_DN_3V3  = 4'd9,
        ST_DN_1V8  = 4'd10,
        ST_DN_1V2  = 4'd11,
        ST_FAULT   = 4'd12
    } state_t;

    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_1V2_TIMEOUT  = 3'd1;
    localparam logic [2:0] FC_1V8_TIMEOUT  = 3'd2;
    localparam logic [2:0] FC_3V3_TIMEOUT  = 3'd3;
    localparam logic [2:0] FC_RAIL_LOST    = 3'd4;

    localparam logic [31:0] DEF_STEP_DELAY    = 32'd1000000;
    localparam logic [31:0] DEF_PGOOD_TIMEOUT = 32'd5000000;
    localparam logic [31:0] DEF_OFF_DELAY     = 32'd100000;

    // Number of monitored rails (1V2, 1V8, 3V3 in bit order 0..2)
    localparam int PGOOD_W = 3;

    // Enable vector layout, in power-up order
    localparam int EN_1V2  = 0;
    localparam int EN_1V8  = 1;
    localparam int EN_3V3  = 2;
    localparam int EN_XCLR = 3;
    localparam int EN_INCK = 4;
    localparam int EN_W    = 5;

    function automatic logic is_busy(input state_t s);
        return (s inside {ST_UP_1V2, ST_UP_1V8, ST_UP_3V3, ST_UP_XCLR, ST_UP_INCK,
                          ST_DN_INCK, ST_DN_XCLR, ST_DN_3V3, ST_DN_1V8, ST_DN_1V2});
    endfunction

endpackage

// File: rtl/cam_pwr_pgood_sync.sv
// -----------------------------------------------------------------------------
// cam_pwr_pgood_sync
// Two-flop synchronizer for the asynchronous regulator power-good inputs.
// Each bit is synchronized independently; the rails are unrelated signals, so
// no cross-bit coherency is needed.
// Ports:
//   clk      : control clock
//   rst_n    : asynchronous active-low reset, clears both stages to 0
//   async_in : raw power-good inputs
//   sync_out : synchronized power-good (2 cycles of latency)
// -----------------------------------------------------------------------------
module cam_pwr_pgood_sync
    import cam_pwr_pkg::*;
#(
    parameter int WIDTH = PGOOD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_out[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/camera_power_ctrl.sv
// -----------------------------------------------------------------------------
// camera_power_ctrl
// Camera sensor power sequencer. Powers up 1V2 -> 1V8 -> 3V3 -> XCLR -> INCK,
// powers down in reverse order, and (optionally) supervises the regulator
// power-good signals, forcing a safe shutdown with a latched fault code.
//
// Build option: define CAM_PWR_PGOOD_CHECK_EN to enable closed-loop power-good
// checking (timeouts, READY monitoring, fault reporting). Without it the
// power-good inputs are ignored, every step lasts STEP_DELAY cycles and the
// fault outputs are constant 0.
//
// Ports:
//   ctrl_clk_i      : control clock
//   ctrl_rst_n_i    : asynchronous active-low reset
//   pwr_on_req_i    : one-cycle power-up request
//   pwr_off_req_i   : one-cycle power-down / fault-clear request
//   pgood_*_i       : asynchronous regulator power-good inputs
//   reg_*_en_o      : regulator enables
//   xclr_o          : sensor XCLR (1 = released)
//   inck_en_o       : sensor input clock enable
//   pwr_ready_o     : sequence complete
//   pwr_busy_o      : power-up or power-down in progress
//   fault_o         : sticky fault flag
//   fault_code_o    : 0 none, 1/2/3 rail timeout, 4 rail lost in READY
// -----------------------------------------------------------------------------
module camera_power_ctrl
    import cam_pwr_pkg::*;
#(
    parameter logic [31:0] STEP_DELAY    = DEF_STEP_DELAY,
    parameter logic [31:0] PGOOD_TIMEOUT = DEF_PGOOD_TIMEOUT,
    parameter logic [31:0] OFF_DELAY     = DEF_OFF_DELAY
) (
    input  logic       ctrl_clk_i,
    input  logic       ctrl_rst_n_i,
    input  logic       pwr_on_req_i,
    input  logic       pwr_off_req_i,
    input  logic       pgood_1v2_i,
    input  logic       pgood_1v8_i,
    input  logic       pgood_3v3_i,
    output logic       reg_1v2_en_o,
    output logic       reg_1v8_en_o,
    output logic       reg_3v3_en_o,
    output logic       xclr_o,
    output logic       inck_en_o,
    output logic       pwr_ready_o,
    output logic       pwr_busy_o,
    output logic       fault_o,
    output logic [2:0] fault_code_o
);

    state_t            state_reg;
    state_t            state_next;
    logic [31:0]       count_reg;
    logic [EN_W-1:0]   en_reg;
    logic              ready_reg;
    logic              busy_reg;

    // Power-good as seen by the sequencer; all ones when checking is disabled
    logic [PGOOD_W-1:0] pg_ok;
    logic               rail_pg;
    logic               rail_timeout;
    logic               rail_lost;
    state_t             rail_next;

`ifdef CAM_PWR_PGOOD_CHECK_EN
    logic [PGOOD_W-1:0] pgood_sync;
    logic               fault_reg;
    logic [2:0]         fault_code_reg;
    logic [2:0]         fault_code_next;
    logic [2:0]         rail_code;

    cam_pwr_pgood_sync #(
        .WIDTH (PGOOD_W)
    ) u_pgood_sync (
        .clk      (ctrl_clk_i),
        .rst_n    (ctrl_rst_n_i),
        .async_in ({pgood_3v3_i, pgood_1v8_i, pgood_1v2_i}),
        .sync_out (pgood_sync)
    );

    assign pg_ok        = pgood_sync;
    assign rail_timeout = !rail_pg && (count_reg == PGOOD_TIMEOUT - 32'd1);
    assign rail_lost    = (pg_ok != {PGOOD_W{1'b1}});
`else
    // Power-good inputs and the timeout are deliberately unused in open-loop mode
    logic unused_pgood;
    assign unused_pgood = ^{pgood_3v3_i, pgood_1v8_i, pgood_1v2_i, PGOOD_TIMEOUT};

    assign pg_ok        = {PGOOD_W{1'b1}};
    assign rail_timeout = 1'b0;
    assign rail_lost    = 1'b0;
`endif

    // Select the rail under test for the three regulator steps
    always_comb begin
        rail_pg   = 1'b1;
        rail_next = ST_UP_1V8;
`ifdef CAM_PWR_PGOOD_CHECK_EN
        rail_code = FC_NONE;
`endif
        case (state_reg)
            ST_UP_1V2: begin
                rail_pg   = pg_ok[0];
                rail_next = ST_UP_1V8;
`ifdef CAM_PWR_PGOOD_CHECK_EN
                rail_code = FC_1V2_TIMEOUT;
`endif
            end
            ST_UP_1V8: begin
                rail_pg   = pg_ok[1];
                rail_next = ST_UP_3V3;
`ifdef CAM_PWR_PGOOD_CHECK_EN
                rail_code = FC_1V8_TIMEOUT;
`endif
            end
            ST_UP_3V3: begin
                rail_pg   = pg_ok[2];
                rail_next = ST_UP_XCLR;
`ifdef CAM_PWR_PGOOD_CHECK_EN
                rail_code = FC_3V3_TIMEOUT;
`endif
            end
            default: ;
        endcase
    end

    // Next-state decision. Priority inside each state: fault, then off
    // request, then normal advance.
    always_comb begin
        state_next = state_reg;
`ifdef CAM_PWR_PGOOD_CHECK_EN
        fault_code_next = fault_code_reg;
`endif
        case (state_reg)
            ST_OFF: begin
                // Off wins over a coincident on request
                if (pwr_on_req_i && !pwr_off_req_i) begin
                    state_next = ST_UP_1V2;
                end
            end
            ST_UP_1V2, ST_UP_1V8, ST_UP_3V3: begin
                if (rail_timeout) begin
                    state_next = ST_FAULT;
`ifdef CAM_PWR_PGOOD_CHECK_EN
                    fault_code_next = rail_code;
`endif
                end else if (pwr_off_req_i) begin
                    state_next = ST_DN_INCK;
                end else if (rail_pg && (count_reg >= STEP_DELAY - 32'd1)) begin
                    state_next = rail_next;
                end
            end
            ST_UP_XCLR: begin
                if (pwr_off_req_i) begin
                    state_next = ST_DN_INCK;
                end else if (count_reg == STEP_DELAY - 32'd1) begin
                    state_next = ST_UP_INCK;
                end
            end
            ST_UP_INCK: begin
                if (pwr_off_req_i) begin
                    state_next = ST_DN_INCK;
                end else if (count_reg == STEP_DELAY - 32'd1) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (rail_lost) begin
                    state_next = ST_FAULT;
`ifdef CAM_PWR_PGOOD_CHECK_EN
                    fault_code_next = FC_RAIL_LOST;
`endif
                end else if (pwr_off_req_i) begin
                    state_next = ST_DN_INCK;
                end
            end
            ST_DN_INCK: if (count_reg == OFF_DELAY - 32'd1) state_next = ST_DN_XCLR;
            ST_DN_XCLR: if (count_reg == OFF_DELAY - 32'd1) state_next = ST_DN_3V3;
            ST_DN_3V3:  if (count_reg == OFF_DELAY - 32'd1) state_next = ST_DN_1V8;
            ST_DN_1V8:  if (count_reg == OFF_DELAY - 32'd1) state_next = ST_DN_1V2;
            ST_DN_1V2:  if (count_reg == OFF_DELAY - 32'd1) state_next = ST_OFF;
            ST_FAULT: begin
                if (pwr_off_req_i) begin
                    state_next = ST_OFF;
`ifdef CAM_PWR_PGOOD_CHECK_EN
                    fault_code_next = FC_NONE;
`endif
                end
            end
            // Unused encodings recover to the safe unpowered state
            default: state_next = ST_OFF;
        endcase
    end

    // State, step counter and all outputs share one register stage so the
    // outputs already reflect the new state in its first cycle. Enables are
    // modified incrementally: a DN step clears only its own output, which keeps
    // an aborted power-up consistent with whatever was already enabled.
    always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
        if (!ctrl_rst_n_i) begin
            state_reg      <= ST_OFF;
            count_reg      <= '0;
            en_reg         <= '0;
            ready_reg      <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef CAM_PWR_PGOOD_CHECK_EN
            fault_reg      <= 1'b0;
            fault_code_reg <= FC_NONE;
`endif
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) begin
                count_reg <= '0;
                ready_reg <= (state_next == ST_READY);
                busy_reg  <= is_busy(state_next);
                case (state_next)
                    ST_UP_1V2:  en_reg[EN_1V2]  <= 1'b1;
                    ST_UP_1V8:  en_reg[EN_1V8]  <= 1'b1;
                    ST_UP_3V3:  en_reg[EN_3V3]  <= 1'b1;
                    ST_UP_XCLR: en_reg[EN_XCLR] <= 1'b1;
                    ST_UP_INCK: en_reg[EN_INCK] <= 1'b1;
                    ST_READY:   en_reg          <= '1;
                    ST_DN_INCK: en_reg[EN_INCK] <= 1'b0;
                    ST_DN_XCLR: en_reg[EN_XCLR] <= 1'b0;
                    ST_DN_3V3:  en_reg[EN_3V3]  <= 1'b0;
                    ST_DN_1V8:  en_reg[EN_1V8]  <= 1'b0;
                    ST_DN_1V2:  en_reg[EN_1V2]  <= 1'b0;
                    default:    en_reg          <= '0;   // OFF and FAULT
                endcase
`ifdef CAM_PWR_PGOOD_CHECK_EN
                fault_reg      <= (state_next == ST_FAULT);
                fault_code_reg <= fault_code_next;
`endif
            end else begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

    assign reg_1v2_en_o = en_reg[EN_1V2];
    assign reg_1v8_en_o = en_reg[EN_1V8];
    assign reg_3v3_en_o = en_reg[EN_3V3];
    assign xclr_o       = en_reg[EN_XCLR];
    assign inck_en_o    = en_reg[EN_INCK];
    assign pwr_ready_o  = ready_reg;
    assign pwr_busy_o   = busy_reg;

`ifdef CAM_PWR_PGOOD_CHECK_EN
    assign fault_o      = fault_reg;
    assign fault_code_o = fault_code_reg;
`else
    assign fault_o      = 1'b0;
    assign fault_code_o = FC_NONE;
`endif

endmodule

// File: tb/tb_camera_power_ctrl.sv
// -----------------------------------------------------------------------------
// tb_camera_power_ctrl
// Directed scenarios followed by randomized requests / power-good activity.
// Every cycle the DUT outputs are compared with a behavioural model that
// tracks the sequence as "phase + number of rails handled + hold time" and the
// set of enabled outputs. Fault scenarios run only when
// CAM_PWR_PGOOD_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_camera_power_ctrl;

    localparam logic [31:0] SD = 32'd10;
    localparam logic [31:0] TO = 32'd20;
    localparam logic [31:0] OD = 32'd5;

`ifdef CAM_PWR_PGOOD_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    // Output vector bit positions
    localparam int B_1V2 = 0, B_1V8 = 1, B_3V3 = 2, B_XCLR = 3, B_INCK = 4;
    localparam int B_FAULT = 8, B_BUSY = 9, B_READY = 10;

    // Model phases
    localparam int M_OFF = 0, M_UP = 1, M_READY = 2, M_DOWN = 3, M_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       on_req = 1'b0;
    logic       off_req = 1'b0;
    logic [2:0] pg = 3'b000;
    logic       en_1v2, en_1v8, en_3v3, xclr, inck_en, ready, busy, fault;
    logic [2:0] fault_code;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_mode;
    int         m_step;   // UP: rails/outputs enabled so far (1..5); DOWN: output being cleared (4..0)
    int         m_cnt;    // cycles already spent in the current step
    logic [4:0] m_mask;
    logic [2:0] m_code;
    logic [2:0] m_s1, m_s2;

    always #5 clk = ~clk;

    camera_power_ctrl #(
        .STEP_DELAY    (SD),
        .PGOOD_TIMEOUT (TO),
        .OFF_DELAY     (OD)
    ) dut (
        .ctrl_clk_i    (clk),
        .ctrl_rst_n_i  (rst_n),
        .pwr_on_req_i  (on_req),
        .pwr_off_req_i (off_req),
        .pgood_1v2_i   (pg[0]),
        .pgood_1v8_i   (pg[1]),
        .pgood_3v3_i   (pg[2]),
        .reg_1v2_en_o  (en_1v2),
        .reg_1v8_en_o  (en_1v8),
        .reg_3v3_en_o  (en_3v3),
        .xclr_o        (xclr),
        .inck_en_o     (inck_en),
        .pwr_ready_o   (ready),
        .pwr_busy_o    (busy),
        .fault_o       (fault),
        .fault_code_o  (fault_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [10:0] dut_vec();
        return {ready, busy, fault, fault_code, inck_en, xclr, en_3v3, en_1v8, en_1v2};
    endfunction

    function automatic logic [10:0] model_vec();
        logic [10:0] v;
        v[4:0]  = m_mask;
        v[7:5]  = m_code;
        v[8]    = (m_mode == M_FAULT);
        v[9]    = (m_mode == M_UP) || (m_mode == M_DOWN);
        v[10]   = (m_mode == M_READY);
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_OFF;
        m_step = 0;
        m_cnt  = 0;
        m_mask = 5'h00;
        m_code = 3'd0;
        m_s1   = 3'b000;
        m_s2   = 3'b000;
    endtask

    // One clock edge of the specified behaviour; m_s2 is the power-good value
    // visible to the sequencer two edges after it was driven.
    task automatic model_step(input logic on, input logic off, input logic [2:0] pg_in);
        int   nmode;
        int   nstep;
        logic rail_good;
        nmode = m_mode;
        nstep = m_step;
        case (m_mode)
            M_OFF: begin
                if (on && !off) begin
                    nmode = M_UP;
                    nstep = 1;
                end
            end
            M_UP: begin
                rail_good = 1'b1;
                if (CHECK && m_step <= 3) rail_good = m_s2[m_step-1];
                if (!rail_good && m_cnt == int'(TO) - 1) begin
                    nmode  = M_FAULT;
                    m_code = 3'(m_step);
                end else if (off) begin
                    nmode = M_DOWN;
                    nstep = 4;
                end else if (rail_good && m_cnt >= int'(SD) - 1) begin
                    if (m_step == 5) nmode = M_READY;
                    else             nstep = m_step + 1;
                end
            end
            M_READY: begin
                if (CHECK && m_s2 != 3'b111) begin
                    nmode  = M_FAULT;
                    m_code = 3'd4;
                end else if (off) begin
                    nmode = M_DOWN;
                    nstep = 4;
                end
            end
            M_DOWN: begin
                if (m_cnt == int'(OD) - 1) begin
                    if (m_step == 0) nmode = M_OFF;
                    else             nstep = m_step - 1;
                end
            end
            default: begin
                if (off) begin
                    nmode  = M_OFF;
                    m_code = 3'd0;
                end
            end
        endcase
        if (nmode != m_mode || nstep != m_step) begin
            m_cnt = 0;
            case (nmode)
                M_UP:    m_mask[nstep-1] = 1'b1;
                M_READY: m_mask = 5'h1f;
                M_DOWN:  m_mask[nstep] = 1'b0;
                default: m_mask = 5'h00;
            endcase
        end else begin
            m_cnt++;
        end
        m_mode = nmode;
        m_step = nstep;
        m_s2   = m_s1;
        m_s1   = pg_in;
    endtask

    // Drive inputs, take one clock edge, advance the model, compare all outputs.
    task automatic cycle(input logic on, input logic off, input logic [2:0] pg_in);
        on_req  = on;
        off_req = off;
        pg      = pg_in;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(on, off, pg_in);
        #1;
        check("outs", 32'(dut_vec()), 32'(model_vec()));
    endtask

    // Run idle cycles until output bit reaches level; check the cycle count.
    task automatic wait_for(input string tag, input int bit_idx, input logic level,
                            input logic [2:0] pg_in, input int exp_n);
        int          n;
        logic [10:0] v;
        n = 0;
        do begin
            cycle(1'b0, 1'b0, pg_in);
            n++;
            v = dut_vec();
        end while (v[bit_idx] !== level && n < 200);
        check(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic idle(input int n, input logic [2:0] pg_in);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, pg_in);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [10:0] v;
        model_reset();
        #1;
        check("reset_state", 32'(dut_vec()), 32'h0);
        idle(3, 3'b111);
        rst_n = 1'b1;
        idle(3, 3'b111);

        // 1: full power-up at 10-cycle spacing
        $display("[TB] test 1: power-up with all rails good");
        cycle(1'b1, 1'b0, 3'b111);
        v = dut_vec();
        check("up_1v2_first", 32'(v[B_1V2]), 32'd1);
        wait_for("up_1v8_gap",  B_1V8,   1'b1, 3'b111, 10);
        wait_for("up_3v3_gap",  B_3V3,   1'b1, 3'b111, 10);
        wait_for("up_xclr_gap", B_XCLR,  1'b1, 3'b111, 10);
        wait_for("up_inck_gap", B_INCK,  1'b1, 3'b111, 10);
        wait_for("up_ready_gap", B_READY, 1'b1, 3'b111, 10);
        v = dut_vec();
        check("ready_busy", 32'(v[B_BUSY]), 32'd0);

        // 3: power-down in reverse order at 5-cycle spacing
        $display("[TB] test 3: power-down from READY");
        cycle(1'b0, 1'b1, 3'b111);
        v = dut_vec();
        check("dn_inck_first", 32'(v[B_INCK]), 32'd0);
        wait_for("dn_xclr_gap", B_XCLR, 1'b0, 3'b111, 5);
        wait_for("dn_3v3_gap",  B_3V3,  1'b0, 3'b111, 5);
        wait_for("dn_1v8_gap",  B_1V8,  1'b0, 3'b111, 5);
        wait_for("dn_1v2_gap",  B_1V2,  1'b0, 3'b111, 5);
        wait_for("dn_off_gap",  B_BUSY, 1'b0, 3'b111, 5);

`ifdef CAM_PWR_PGOOD_CHECK_EN
        // 2: 1V8 power-good never arrives
        $display("[TB] test 2: 1V8 power-good timeout");
        idle(3, 3'b101);
        cycle(1'b1, 1'b0, 3'b101);
        wait_for("to_1v8_rise", B_1V8, 1'b1, 3'b101, 10);
        wait_for("to_fault_gap", B_FAULT, 1'b1, 3'b101, 20);
        v = dut_vec();
        check("to_code", 32'(v[7:5]), 32'd2);
        check("to_enables", 32'(v[4:0]), 32'd0);
        cycle(1'b0, 1'b1, 3'b111);
        v = dut_vec();
        check("to_clear", 32'(v), 32'd0);

        // 4: rail lost while READY
        $display("[TB] test 4: 3V3 drop in READY");
        idle(3, 3'b111);
        cycle(1'b1, 1'b0, 3'b111);
        wait_for("drop_ready", B_READY, 1'b1, 3'b111, 50);
        wait_for("drop_fault_gap", B_FAULT, 1'b1, 3'b011, 3);
        v = dut_vec();
        check("drop_code", 32'(v[7:5]), 32'd4);
        cycle(1'b0, 1'b1, 3'b011);
        v = dut_vec();
        check("drop_clear_fault", 32'(v[B_FAULT]), 32'd0);
        check("drop_clear_code", 32'(v[7:5]), 32'd0);
        idle(3, 3'b111);
`endif

        // 5: abort during UP_1V8, then simultaneous requests in OFF
        $display("[TB] test 5: abort during UP_1V8 and on+off together");
        cycle(1'b1, 1'b0, 3'b111);
        wait_for("abort_1v8", B_1V8, 1'b1, 3'b111, 10);
        idle(3, 3'b111);
        cycle(1'b0, 1'b1, 3'b111);
        v = dut_vec();
        check("abort_busy", 32'(v[B_BUSY]), 32'd1);
        wait_for("abort_walk", B_BUSY, 1'b0, 3'b111, 25);
        cycle(1'b1, 1'b1, 3'b111);
        idle(4, 3'b111);
        v = dut_vec();
        check("onoff_stays_off", 32'(v), 32'd0);

        // 6: asynchronous reset in UP_XCLR
        $display("[TB] test 6: reset during UP_XCLR");
        cycle(1'b1, 1'b0, 3'b111);
        idle(32, 3'b111);
        v = dut_vec();
        check("rst_pre_xclr", 32'(v[B_XCLR]), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async", 32'(dut_vec()), 32'd0);
        idle(2, 3'b111);
        rst_n = 1'b1;
        idle(15, 3'b111);
        check("rst_stays_off", 32'(dut_vec()), 32'd0);

        // Randomized requests, rail glitches and occasional resets
        $display("[TB] random phase");
        for (int c = 0; c < 3000; c++) begin
            logic       r_on, r_off;
            logic [2:0] r_pg;
            r_pg = pg;
            if ($urandom_range(0, 19) == 0) r_pg = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 14) == 0) r_pg = 3'b111;
            r_on  = ($urandom_range(0, 39) == 0);
            r_off = ($urandom_range(0, 59) == 0);
            if (r_on || r_off)
                $display("[TB] rnd cyc %0d on=%0d off=%0d pg=%b", c, r_on, r_off, r_pg);
            if ($urandom_range(0, 499) == 0) begin
                $display("[TB] rnd cyc %0d reset", c);
                rst_n = 1'b0;
                #1;
                model_reset();
                check("rnd_rst", 32'(dut_vec()), 32'd0);
                cycle(r_on, r_off, r_pg);
                rst_n = 1'b1;
            end else begin
                cycle(r_on, r_off, r_pg);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
